// File: rtl/multiplicador_control.sv
// ---------------------------------------------------------------------------
// multiplicador_control
//
// Sequential shift-add unsigned multiplier controller. It holds the
// multiplier registers (M, C, A, Q, Cnt) and drives one shared external
// N-bit ripple Adder. The result is a 2N-bit product. A Start/Done
// handshake connects it to the CPU multiply unit.
//
// Ports:
//   Clk            rising-edge clock
//   Rst_n          asynchronous active-low reset
//   Start          request, sampled only while idle
//   Multiplicando  N-bit unsigned multiplicand, captured on accepted Start
//   Multiplicador  N-bit unsigned multiplier, captured on accepted Start
//   AdderA         to Adder OperandoA (accumulator register A)
//   AdderB         to Adder OperandoB (multiplicand register M)
//   AdderSoma      from Adder Soma, (N+1)-bit combinational A+M
//   Produto        registered 2N-bit product, held until the next Done
//   Busy           high in every state except IDLE
//   Done           one-cycle pulse when Produto updates
//
// Optional feature (macro MULT_EARLY_EXIT_EN):
//   When defined, CHECK detects that every remaining multiplier bit is zero.
//   It then jumps to FINISH, which does all remaining shifts in one cycle.
//   Products are unchanged and only latency shrinks. When the macro is
//   undefined, the FINISH state and the zero-detect logic are not built.
// ---------------------------------------------------------------------------
module multiplicador_control #(
  parameter int N = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [N-1:0]     Multiplicando,
  input  logic [N-1:0]     Multiplicador,
  output logic [N-1:0]     AdderA,
  output logic [N-1:0]     AdderB,
  input  logic [N:0]       AdderSoma,
  output logic [2*N-1:0]   Produto,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ADD    = 3'd2,
    S_SHIFT  = 3'd3,
    S_DONE   = 3'd4
`ifdef MULT_EARLY_EXIT_EN
    ,
    S_FINISH = 3'd5
`endif
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_m;
  logic               r_c;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*N-1:0]     r_produto;
  logic               r_busy;
  logic               r_done;

`ifdef MULT_EARLY_EXIT_EN
  // After Cnt shifts, only Q[N-1-Cnt:0] still holds unprocessed multiplier
  // bits. The upper Cnt bits of Q already hold low product bits.
  logic [N-1:0]       w_rem_mask;
  logic               w_rem_zero;
  logic [CNT_W:0]     w_shamt;
  logic [2*N:0]       w_finish_val;

  always_comb begin
    w_rem_mask   = '1;
    w_rem_mask   = w_rem_mask >> r_cnt;
    w_rem_zero   = ((r_q & w_rem_mask) == '0);
    w_shamt      = (CNT_W+1)'(N) - {1'b0, r_cnt};
    w_finish_val = {r_c, r_a, r_q} >> w_shamt;
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_c       <= 1'b0;
      r_a       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_produto <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_m     <= Multiplicando;
            r_q     <= Multiplicador;
            r_c     <= 1'b0;
            r_a     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
`ifdef MULT_EARLY_EXIT_EN
          if (w_rem_zero)    r_state <= S_FINISH;
          else if (r_q[0])   r_state <= S_ADD;
          else               r_state <= S_SHIFT;
`else
          if (r_q[0]) r_state <= S_ADD;
          else        r_state <= S_SHIFT;
`endif
        end
        S_ADD: begin
          // Keep the adder carry out so the product cannot overflow.
          {r_c, r_a} <= AdderSoma;
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[N-1:1]};
          r_cnt           <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N-1)) r_state <= S_DONE;
          else                      r_state <= S_CHECK;
        end
`ifdef MULT_EARLY_EXIT_EN
        S_FINISH: begin
          {r_c, r_a, r_q} <= w_finish_val;
          r_state         <= S_DONE;
        end
`endif
        S_DONE: begin
          r_produto <= {r_a, r_q};
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign AdderA  = r_a;
  assign AdderB  = r_m;
  assign Produto = r_produto;
  assign Busy    = r_busy;
  assign Done    = r_done;

endmodule

// File: tb/tb_multiplicador_control.sv
// ---------------------------------------------------------------------------
// tb_multiplicador_control
//
// Directed testbench for multiplicador_control (N=4). It models the
// external ripple Adder as a combinational A+M. It checks the product,
// the Done latency, Busy and the reset behaviour against hand-derived
// values.
// ---------------------------------------------------------------------------
module tb_multiplicador_control;

  localparam int N = 4;

  logic             Clk;
  logic             Rst_n;
  logic             Start;
  logic [N-1:0]     Multiplicando;
  logic [N-1:0]     Multiplicador;
  logic [N-1:0]     AdderA;
  logic [N-1:0]     AdderB;
  logic [N:0]       AdderSoma;
  logic [2*N-1:0]   Produto;
  logic             Busy;
  logic             Done;

  int n_tests = 0;
  int n_fail  = 0;

  multiplicador_control #(.N(N)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Start         (Start),
    .Multiplicando (Multiplicando),
    .Multiplicador (Multiplicador),
    .AdderA        (AdderA),
    .AdderB        (AdderB),
    .AdderSoma     (AdderSoma),
    .Produto       (Produto),
    .Busy          (Busy),
    .Done          (Done)
  );

  // External ripple Adder: (N+1)-bit sum of the two N-bit operands.
  assign AdderSoma = {1'b0, AdderA} + {1'b0, AdderB};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles from the Start-sampling edge to the Done edge, one per state visited.
  function automatic int exp_lat(input int j);
    int lat;
    lat = 0;
    for (int c = 0; c < N; c++) begin
      lat++;
`ifdef MULT_EARLY_EXIT_EN
      if ((j >> c) == 0) return lat + 2;
`endif
      if (((j >> c) & 1) == 1) lat++;
      lat++;
    end
    return lat + 1;
  endfunction

  // mode 0: single Start pulse; 1: Start held high; 2: second Start pulse
  // while busy; 3: operands scrambled every cycle while busy.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int mode,
                        output logic [2*N-1:0] prod, output int lat, output int busy_cyc);
    @(negedge Clk);
    Multiplicando = a;
    Multiplicador = b;
    Start = 1'b1;
    @(posedge Clk); #1;
    if (mode != 1) Start = 1'b0;
    lat = -1;
    busy_cyc = 0;
    prod = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (Done) begin
        lat = k;
        prod = Produto;
        break;
      end
      if (Busy) busy_cyc++;
      if (mode == 2 && k == 4) begin
        Start = 1'b1;
        Multiplicando = 4'd7;
        Multiplicador = 4'd7;
      end
      if (mode == 2 && k == 5) Start = 1'b0;
      if (mode == 3) begin
        Multiplicando = 4'($urandom);
        Multiplicador = 4'($urandom);
      end
    end
  endtask

  initial begin
    logic [2*N-1:0] prod;
    int lat;
    int busy_cyc;
    int done_cnt;

    Rst_n = 1'b0;
    Start = 1'b0;
    Multiplicando = '0;
    Multiplicador = '0;
    #3;
    check("rst_busy",    32'(Busy),    32'd0);
    check("rst_done",    32'(Done),    32'd0);
    check("rst_produto", 32'(Produto), 32'd0);
    check("rst_adderA",  32'(AdderA),  32'd0);
    check("rst_adderB",  32'(AdderB),  32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // 15x15: worst-case latency without early exit.
    run_op(4'd15, 4'd15, 0, prod, lat, busy_cyc);
    check("p15x15",    32'(prod), 32'd225);
    check("lat15x15",  32'(lat),  32'(exp_lat(15)));
`ifndef MULT_EARLY_EXIT_EN
    check("busy15x15", 32'(busy_cyc), 32'd12);
`endif
    @(posedge Clk); #1;
    check("done_pulse_width", 32'(Done),    32'd0);
    check("produto_hold",     32'(Produto), 32'd225);
    check("idle_busy",        32'(Busy),    32'd0);

    // Exhaustive, back-to-back with Start held high.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), 1, prod, lat, busy_cyc);
        check($sformatf("p%0dx%0d", i, j),   32'(prod), 32'(i * j));
        check($sformatf("lat%0dx%0d", i, j), 32'(lat),  32'(exp_lat(j)));
      end
    end
    Start = 1'b0;

    // 9x0: zero multiplier.
    run_op(4'd9, 4'd0, 0, prod, lat, busy_cyc);
    check("p9x0",   32'(prod), 32'd0);
    check("lat9x0", 32'(lat),  32'(exp_lat(0)));

    // 5x3 with a 7x7 request while busy, which must be ignored.
    run_op(4'd5, 4'd3, 2, prod, lat, busy_cyc);
    check("p5x3_ignore", 32'(prod), 32'd15);
    check("lat5x3",      32'(lat),  32'(exp_lat(3)));
    done_cnt = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    check("no_second_done", 32'(done_cnt), 32'd0);
    check("idle_after_ign", 32'(Busy),     32'd0);

    // 12x11 aborted by reset mid-operation.
    @(negedge Clk);
    Multiplicando = 4'd12;
    Multiplicador = 4'd11;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    check("pre_abort_busy",   32'(Busy),   32'd1);
    check("pre_abort_adderB", 32'(AdderB), 32'd12);
    Rst_n = 1'b0;
    #1;
    check("abort_busy",    32'(Busy),    32'd0);
    check("abort_produto", 32'(Produto), 32'd0);
    check("abort_adderA",  32'(AdderA),  32'd0);
    check("abort_adderB",  32'(AdderB),  32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (15) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(4'd2, 4'd3, 0, prod, lat, busy_cyc);
    check("p2x3_after_abort", 32'(prod), 32'd6);
    check("lat2x3",           32'(lat),  32'(exp_lat(3)));

    // 10x6 with operand inputs changing every cycle during the operation.
    run_op(4'd10, 4'd6, 3, prod, lat, busy_cyc);
    check("p10x6_scramble", 32'(prod), 32'd60);
    check("lat10x6",        32'(lat),  32'(exp_lat(6)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
